// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared timer to N_REQ requesters and returns a done pulse per run.
// Optional build macro TIMER_ARB_ABORT_EN: the owner dropping req during LOAD/RUN aborts its run.
module timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 18
) (
    input  logic                   clkSignal,
    input  logic                   nRST,
    input  logic                   EN,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] reqCount,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic [CNT_W-1:0]       tmrMaxCount,
    output logic                   tmrEN,
    output logic                   tmrRST,
    input  logic                   tmrFinish
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           nextState_s;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] owner_r;
    logic [PTR_W-1:0] winIdx_s;
    logic [PTR_W-1:0] candIdx_s;
    logic [PTR_W-1:0] nextPtr_s;
    int               cand_s;
    logic             found_s;
    logic             doGrant_s;
    logic             advPtr_s;
    logic [N_REQ-1:0] grant_r;
    logic [N_REQ-1:0] done_r;
    logic             busy_r;
    logic [CNT_W-1:0] maxCount_r;
    logic [CNT_W-1:0] countArr_s [N_REQ];

    // Split the flat count bus into one entry per requester
    for (genvar g = 0; g < N_REQ; g++) begin : gCount
        assign countArr_s[g] = reqCount[g*CNT_W +: CNT_W];
    end

    // Round-robin search: first set req at or above the pointer, wrapping at N_REQ-1
    always_comb begin
        found_s   = 1'b0;
        winIdx_s  = ptr_r;
        cand_s    = 32'sd0;
        candIdx_s = {PTR_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s    = (int'(ptr_r) + k >= N_REQ) ? int'(ptr_r) + k - N_REQ : int'(ptr_r) + k;
            candIdx_s = PTR_W'(cand_s);
            if (!found_s && req[candIdx_s]) begin
                found_s  = 1'b1;
                winIdx_s = candIdx_s;
            end else begin
                winIdx_s = winIdx_s;
            end
        end
    end

    assign nextPtr_s = (owner_r == LAST_IDX) ? {PTR_W{1'b0}} : owner_r + PTR_W'(1);

    // Next-state decode; EN low outranks both the owner's finish and its req
    always_comb begin
        nextState_s = state_r;
        doGrant_s   = 1'b0;
        advPtr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (EN && found_s) begin
                    nextState_s = LOAD;
                    doGrant_s   = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            LOAD: begin
                if (!EN) begin
                    nextState_s = IDLE;
`ifdef TIMER_ARB_ABORT_EN
                end else if (!req[owner_r]) begin
                    nextState_s = IDLE;
                    advPtr_s    = 1'b1;
`endif
                end else if (maxCount_r == {CNT_W{1'b0}}) begin
                    // A zero count would never finish, so skip the timer entirely
                    nextState_s = DONE;
                end else begin
                    nextState_s = RUN;
                end
            end
            RUN: begin
                if (!EN) begin
                    nextState_s = IDLE;
`ifdef TIMER_ARB_ABORT_EN
                end else if (!req[owner_r]) begin
                    nextState_s = IDLE;
                    advPtr_s    = 1'b1;
`endif
                end else if (tmrFinish) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = RUN;
                end
            end
            DONE: begin
                nextState_s = IDLE;
                advPtr_s    = 1'b1;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State, grant latch, pointer and registered outputs
    always_ff @(posedge clkSignal) begin
        if (!nRST) begin
            state_r    <= IDLE;
            grant_r    <= {N_REQ{1'b0}};
            done_r     <= {N_REQ{1'b0}};
            busy_r     <= 1'b0;
            maxCount_r <= {CNT_W{1'b0}};
            ptr_r      <= {PTR_W{1'b0}};
            owner_r    <= {PTR_W{1'b0}};
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s != IDLE);
            // The pulse follows DONE by one cycle, so it survives EN dropping in DONE
            done_r  <= (state_r == DONE) ? grant_r : {N_REQ{1'b0}};
            if (doGrant_s) begin
                grant_r    <= ONE_HOT_0 << winIdx_s;
                owner_r    <= winIdx_s;
                maxCount_r <= countArr_s[winIdx_s];
            end else if (nextState_s == IDLE) begin
                grant_r <= {N_REQ{1'b0}};
            end else begin
                grant_r <= grant_r;
            end
            if (advPtr_s) begin
                ptr_r <= nextPtr_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign grant       = grant_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign tmrMaxCount = maxCount_r;
    assign tmrEN       = (state_r == RUN);
    assign tmrRST      = (state_r != RUN);

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a behavioural model of the shared timer.
// Build with TIMER_ARB_ABORT_EN to exercise the owner-abort feature.
module tb_timer_arbiter;

    logic        clkSignal;
    logic        nRST;
    logic        EN;
    logic [3:0]  req;
    logic [71:0] reqCount;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done;
    logic [17:0] tmrMaxCount;
    logic        tmrEN;
    logic        tmrRST;
    logic        tmrFinish;
    logic [17:0] tmrCnt;

    int   checkCnt = 0;
    int   passCnt  = 0;
    logic enSeen;

    timer_arbiter #(.N_REQ(4), .CNT_W(18)) dut (
        .clkSignal  (clkSignal),
        .nRST       (nRST),
        .EN         (EN),
        .req        (req),
        .reqCount   (reqCount),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .tmrMaxCount(tmrMaxCount),
        .tmrEN      (tmrEN),
        .tmrRST     (tmrRST),
        .tmrFinish  (tmrFinish)
    );

    initial clkSignal = 1'b0;
    always #5 clkSignal = ~clkSignal;

    // Shared timer model: finish is high during the M-th cycle that EN is high
    always_ff @(posedge clkSignal) begin
        if (tmrRST) tmrCnt <= 18'd0;
        else if (tmrEN) tmrCnt <= tmrCnt + 18'd1;
    end
    assign tmrFinish = tmrEN && (tmrMaxCount != 18'd0) && (tmrCnt == tmrMaxCount - 18'd1);

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic stepClk();
        @(posedge clkSignal);
        #1;
    endtask

    task automatic setCount(input int idx, input logic [17:0] val);
        reqCount[idx*18 +: 18] = val;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        stepClk();
        stepClk();
        nRST = 1'b1;
    endtask

    task automatic waitGrant(input string tag, input logic [3:0] expGrant, input logic [17:0] expCount);
        int n = 0;
        while (grant == 4'b0000 && n < 200) begin
            stepClk();
            n++;
        end
        checkEq({tag, "_grant"}, 32'(grant), 32'(expGrant));
        checkEq({tag, "_maxcnt"}, 32'(tmrMaxCount), 32'(expCount));
    endtask

    // Counts cycles from the current (grant) cycle to the done pulse
    task automatic waitDone(input string tag, input logic [3:0] expDone, input int expLat,
                            input logic [3:0] dropMask);
        int n = 0;
        enSeen = 1'b0;
        while (done == 4'b0000 && n < 200) begin
            if (tmrEN) enSeen = 1'b1;
            stepClk();
            n++;
        end
        checkEq({tag, "_lat"}, 32'(n), 32'(expLat));
        checkEq({tag, "_done"}, 32'(done), 32'(expDone));
        checkEq({tag, "_busyAtDone"}, 32'(busy), 32'd0);
        req = req & ~dropMask;
        stepClk();
        checkEq({tag, "_pulseWidth"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [3:0] order [5];
        logic       doneSeen;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        EN = 1'b1;
        req = 4'b1111;
        reqCount = 72'd0;
        for (int i = 0; i < 4; i++) setCount(i, 18'd3);

        // Reset with every requester asserted, then full round-robin rotation
        nRST = 1'b0;
        stepClk();
        stepClk();
        checkEq("rst_grant", 32'(grant), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        checkEq("rst_tmrEN", 32'(tmrEN), 32'd0);
        checkEq("rst_tmrRST", 32'(tmrRST), 32'd1);
        checkEq("rst_done", 32'(done), 32'd0);
        checkEq("rst_maxcnt", 32'(tmrMaxCount), 32'd0);
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitGrant($sformatf("rr%0d", i), order[i], 18'd3);
            waitDone($sformatf("rr%0d", i), order[i], 5, (i == 4) ? 4'b1111 : 4'b0000);
        end

        // Single request, count 10; a later reqCount change must be ignored
        doReset();
        setCount(2, 18'd10);
        req = 4'b0100;
        waitGrant("single", 4'b0100, 18'd10);
        setCount(2, 18'd3);
        waitDone("single", 4'b0100, 12, 4'b0100);
        checkEq("single_latched", 32'(tmrMaxCount), 32'd10);

        // Zero count skips the timer
        doReset();
        setCount(1, 18'd0);
        req = 4'b0010;
        waitGrant("zero", 4'b0010, 18'd0);
        waitDone("zero", 4'b0010, 2, 4'b0010);
        checkEq("zero_tmrEN", 32'(enSeen), 32'd0);

        // EN dropped mid-run aborts without done; re-enable re-grants the same owner
        doReset();
        setCount(0, 18'd20);
        req = 4'b0001;
        waitGrant("abortEn", 4'b0001, 18'd20);
        for (int i = 0; i < 4; i++) stepClk();
        EN = 1'b0;
        stepClk();
        checkEq("abortEn_grant", 32'(grant), 32'd0);
        checkEq("abortEn_busy", 32'(busy), 32'd0);
        checkEq("abortEn_tmrEN", 32'(tmrEN), 32'd0);
        doneSeen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done != 4'b0000) doneSeen = 1'b1;
            stepClk();
        end
        checkEq("abortEn_noDone", 32'(doneSeen), 32'd0);
        EN = 1'b1;
        waitGrant("reEn", 4'b0001, 18'd20);
        waitDone("reEn", 4'b0001, 22, 4'b0001);

`ifdef TIMER_ARB_ABORT_EN
        // Owner drops req mid-run: run aborts, pending req[0] goes next
        doReset();
        setCount(3, 18'd50);
        setCount(0, 18'd3);
        req = 4'b1000;
        waitGrant("ownAbort", 4'b1000, 18'd50);
        req = 4'b1001;
        for (int i = 0; i < 3; i++) stepClk();
        req = 4'b0001;
        stepClk();
        checkEq("ownAbort_grant", 32'(grant), 32'd0);
        checkEq("ownAbort_done", 32'(done), 32'd0);
        waitGrant("ownAbortNext", 4'b0001, 18'd3);
        waitDone("ownAbortNext", 4'b0001, 5, 4'b0001);
`else
        // Owner drops req mid-run: run still completes with done
        doReset();
        setCount(3, 18'd5);
        req = 4'b1000;
        waitGrant("reqDrop", 4'b1000, 18'd5);
        stepClk();
        stepClk();
        req = 4'b0000;
        waitDone("reqDrop", 4'b1000, 5, 4'b0000);
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
